// File: rtl/bch_chien_search_serial.sv
// Serial Chien search for a binary BCH decoder: evaluates the error locator L(x)
// at x = alpha^-j for j = n-1 down to 0, one position per enabled clock.
module bch_chien_search_serial #(
    parameter int m      = 4,
    parameter int k_max  = 5,
    parameter int d      = 7,
    parameter int n      = 15,
    parameter int irrpol = 19,
    parameter int ptr_w  = 4,
    localparam int t     = (d - 1) / 2,
    localparam int CW    = $clog2(t + 1)
) (
    input  logic                 iclk,
    input  logic                 ireset,
    input  logic                 iclkena,
    input  logic                 iloc_poly_val,
    input  logic [m*(t+1)-1:0]   iloc_poly,
    input  logic [ptr_w-1:0]     iloc_poly_ptr,
    output logic                 ordy,
    output logic                 oval,
    output logic                 osop,
    output logic                 oeop,
    output logic                 oerr,
    output logic [ptr_w-1:0]     optr,
    output logic [CW-1:0]        oerr_cnt,
    output logic                 odecfail
);

    localparam int NF      = (1 << m) - 1;
    localparam int PW      = $clog2(n);
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef logic [m-1:0] gf_t;
    typedef enum logic [1:0] {cIDLE, cLOAD, cSEARCH} state_t;

    function automatic gf_t gf_mul_alpha(gf_t a);
        gf_t r;
        r = gf_t'(a << 1);
        if (a[m-1]) r = r ^ gf_t'(irrpol);
        return r;
    endfunction

    // Multiply by alpha^e; e is always an elaboration constant, so this folds to XORs.
    function automatic gf_t gf_mul_pow(gf_t a, int e);
        gf_t r;
        r = a;
        for (int s = 0; s < NF; s++) begin
            if (s < e) r = gf_mul_alpha(r);
        end
        return r;
    endfunction

    state_t          state_q, state_d;
    gf_t             loc      [t+1];
    gf_t             term_q   [t+1];
    logic [CW-1:0]   deg_in, deg_q;
    logic            l0_ok_q;
    logic [PW-1:0]   pos_q;
    logic            active_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    gf_t             sum;
    logic            flag;
    logic            accept;

    logic                val_q, sop_q, eop_q, err_q, decfail_q;
    logic [ptr_w-1:0]    ptr_q;
    logic [CW-1:0]       err_cnt_q;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        deg_in = '0;
        for (int i = 0; i <= t; i++) begin
            loc[i] = iloc_poly[i*m +: m];
        end
        for (int i = 1; i <= t; i++) begin
            if (loc[i] != '0) deg_in = CW'(i);
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i <= t; i++) begin
            sum = sum ^ term_q[i];
        end
    end

    // An L[0]==0 locator is malformed; suppressing its flags makes it report as a decode failure.
    assign flag   = l0_ok_q && (sum == '0);
    assign cnt_d  = (flag && (cnt_q != CW'(CNT_MAX))) ? cnt_q + CW'(1) : cnt_q;
    assign accept = (state_q == cIDLE) && iloc_poly_val;

    always_comb begin
        state_d = state_q;
        case (state_q)
            cIDLE:   if (iloc_poly_val) state_d = cLOAD;
            cLOAD:   state_d = cSEARCH;
            cSEARCH: if (!active_q) state_d = cIDLE;
            default: state_d = cIDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state_q <= cIDLE;
        end else if (iclkena) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            pos_q     <= '0;
            active_q  <= 1'b0;
            cnt_q     <= '0;
            val_q     <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            err_q     <= 1'b0;
            ptr_q     <= '0;
            err_cnt_q <= '0;
            decfail_q <= 1'b0;
        end else if (iclkena) begin
            if (accept) begin
                ptr_q    <= iloc_poly_ptr;
                pos_q    <= PW'(n - 1);
                active_q <= 1'b1;
                cnt_q    <= '0;
            end else if (active_q) begin
                pos_q <= pos_q - PW'(1);
                cnt_q <= cnt_d;
                if (pos_q == '0) active_q <= 1'b0;
            end
            val_q <= active_q;
            sop_q <= active_q && (pos_q == PW'(n - 1));
            eop_q <= active_q && (pos_q == '0);
            err_q <= active_q && flag;
            if (active_q && (pos_q == '0)) begin
                err_cnt_q <= cnt_d;
                decfail_q <= (cnt_d != deg_q);
            end
        end
    end

    // NOTE: the evaluation terms are pure datapath, loaded on accept before use, so they carry no reset.
    always_ff @(posedge iclk) begin
        if (iclkena) begin
            if (accept) begin
                for (int i = 0; i <= t; i++) begin
                    term_q[i] <= gf_mul_pow(loc[i], (i * (NF - n + 1)) % NF);
                end
                deg_q   <= deg_in;
                l0_ok_q <= (loc[0] != '0);
            end else if (active_q) begin
                for (int i = 0; i <= t; i++) begin
                    term_q[i] <= gf_mul_pow(term_q[i], i % NF);
                end
            end
        end
    end

    assign ordy     = (state_q == cIDLE);
    assign oval     = val_q;
    assign osop     = sop_q;
    assign oeop     = eop_q;
    assign oerr     = err_q;
    assign optr     = ptr_q;
    assign oerr_cnt = err_cnt_q;
    assign odecfail = decfail_q;

endmodule

// File: tb/tb_bch_chien_search_serial.sv
// Directed bench for bch_chien_search_serial (m=4, n=15, t=3, x^4+x+1); L[i] sits in iloc_poly[4i+:4].
module tb_bch_chien_search_serial;

    logic        iclk;
    logic        ireset;
    logic        iclkena;
    logic        iloc_poly_val;
    logic [15:0] iloc_poly;
    logic [3:0]  iloc_poly_ptr;
    logic        ordy;
    logic        oval;
    logic        osop;
    logic        oeop;
    logic        oerr;
    logic [3:0]  optr;
    logic [1:0]  oerr_cnt;
    logic        odecfail;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] prev_cnt;
    logic       prev_fail;

    bch_chien_search_serial #(
        .m(4), .k_max(5), .d(7), .n(15), .irrpol(19), .ptr_w(4)
    ) dut (
        .iclk          (iclk),
        .ireset        (ireset),
        .iclkena       (iclkena),
        .iloc_poly_val (iloc_poly_val),
        .iloc_poly     (iloc_poly),
        .iloc_poly_ptr (iloc_poly_ptr),
        .ordy          (ordy),
        .oval          (oval),
        .osop          (osop),
        .oeop          (oeop),
        .oerr          (oerr),
        .optr          (optr),
        .oerr_cnt      (oerr_cnt),
        .odecfail      (odecfail)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge iclk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ordy"}, ordy, 1);
        check({tag, "_oval"}, oval, 0);
        check({tag, "_osop"}, osop, 0);
        check({tag, "_oeop"}, oeop, 0);
        check({tag, "_oerr"}, oerr, 0);
        check({tag, "_optr"}, optr, 0);
        check({tag, "_cnt"},  oerr_cnt, 0);
        check({tag, "_fail"}, odecfail, 0);
    endtask

    // exp_err bit j = 1 when position j is an expected root; the p-th oval carries j = 14-p.
    task automatic run_word(input logic [15:0] poly, input logic [3:0] ptr, input logic [14:0] exp_err,
                            input logic [1:0] exp_cnt, input logic exp_fail, input bit rnd, input bit inject);
        check("ordy_idle", ordy, 1);
        iclkena       = 1'b1;
        iloc_poly_val = 1'b1;
        iloc_poly     = poly;
        iloc_poly_ptr = ptr;
        step();
        iloc_poly_val = 1'b0;
        iloc_poly     = 16'hFFFF;
        iloc_poly_ptr = ~ptr;
        check("c1_oval", oval, 0);
        check("c1_ordy", ordy, 0);
        check("c1_optr", optr, ptr);
        check("c1_cnt_hold", oerr_cnt, prev_cnt);
        check("c1_fail_hold", odecfail, prev_fail);
        for (int p = 0; p < 15; p++) begin
            if (rnd) begin
                repeat ($urandom_range(0, 2)) begin
                    iclkena = 1'b0;
                    step();
                end
            end
            iclkena = 1'b1;
            if (inject && p == 5) iloc_poly_val = 1'b1;
            step();
            iloc_poly_val = 1'b0;
            check("oval", oval, 1);
            check("osop", osop, (p == 0) ? 1 : 0);
            check("oeop", oeop, (p == 14) ? 1 : 0);
            check("oerr", oerr, exp_err[14-p]);
        end
        check("eop_cnt", oerr_cnt, exp_cnt);
        check("eop_fail", odecfail, exp_fail);
        check("eop_ordy", ordy, 0);
        check("eop_optr", optr, ptr);
        step();
        check("post_ordy", ordy, 1);
        check("post_oval", oval, 0);
        check("post_cnt", oerr_cnt, exp_cnt);
        prev_cnt  = exp_cnt;
        prev_fail = exp_fail;
    endtask

    initial begin
        ireset        = 1'b1;
        iclkena       = 1'b1;
        iloc_poly_val = 1'b0;
        iloc_poly     = '0;
        iloc_poly_ptr = '0;
        prev_cnt      = '0;
        prev_fail     = 1'b0;
        #2;
        check_reset_outputs("rst0");
        step();
        step();
        ireset = 1'b0;
        step();
        check_reset_outputs("rst1");

        // L = 1: no roots at all
        run_word(16'h0001, 4'h1, 15'h0000, 2'd0, 1'b0, 1'b0, 1'b0);
        // L = 1 + alpha^5 x: single root at j=5
        run_word(16'h0061, 4'h2, 15'h0020, 2'd1, 1'b0, 1'b0, 1'b0);
        // L = 1 + 8x + 9x^2: roots at j=0 and j=14
        run_word(16'h0981, 4'h3, 15'h4001, 2'd2, 1'b0, 1'b0, 1'b0);
        // L = 1 + x^2: double root at x=1, counted once
        run_word(16'h0101, 4'h4, 15'h0001, 2'd1, 1'b1, 1'b0, 1'b0);
        // L = 1 + 5x + 11x^2 + 15x^3: roots at j=0,13,14, counter at full scale
        run_word(16'hFB51, 4'h5, 15'h6001, 2'd3, 1'b0, 1'b0, 1'b0);
        // L[0]==0 malformed: no flags, decode failure since deg=1
        run_word(16'h0010, 4'h6, 15'h0000, 2'd0, 1'b1, 1'b0, 1'b0);
        // all-zero locator: deg=0, still no flags
        run_word(16'h0000, 4'h7, 15'h0000, 2'd0, 1'b0, 1'b0, 1'b0);
        // stray valid mid-search must be ignored
        run_word(16'h0061, 4'h8, 15'h0020, 2'd1, 1'b0, 1'b0, 1'b1);

        // reset in the middle of a search
        iclkena       = 1'b1;
        iloc_poly_val = 1'b1;
        iloc_poly     = 16'h0981;
        iloc_poly_ptr = 4'h9;
        step();
        iloc_poly_val = 1'b0;
        repeat (6) step();
        check("mid_oval", oval, 1);
        check("mid_ordy", ordy, 0);
        #2;
        ireset = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        step();
        ireset    = 1'b0;
        prev_cnt  = '0;
        prev_fail = 1'b0;
        step();
        check_reset_outputs("rst_post");

        // same words with a randomly stalled clock enable
        run_word(16'h0001, 4'hA, 15'h0000, 2'd0, 1'b0, 1'b1, 1'b0);
        run_word(16'h0061, 4'hB, 15'h0020, 2'd1, 1'b0, 1'b1, 1'b1);
        run_word(16'h0981, 4'hC, 15'h4001, 2'd2, 1'b0, 1'b1, 1'b0);
        run_word(16'h0101, 4'hD, 15'h0001, 2'd1, 1'b1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
